// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage FP add/sub front end (align, significand add, sign/special select).
// Defining FP_ADD_PIPE_EXC_CNT_EN adds the exc_cnt output counting NaN/invalid results.
module fp_add_pipe #(
    parameter int EW = 11,
    parameter int FW = 52
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW:0]   fa,
    input  logic [FW:0]   fb,
    input  logic [EW-1:0] ea,
    input  logic [EW-1:0] eb,
    input  logic          sa,
    input  logic          sb,
    input  logic          sub,
    input  logic [3:0]    fla,
    input  logic [3:0]    flb,
    input  logic [FW:0]   nan,
    input  logic [1:0]    RM,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] es,
    output logic [FW+4:0] fs,
    output logic          ss,
    output logic [FW+5:0] fls
`ifdef FP_ADD_PIPE_EXC_CNT_EN
    ,
    output logic [15:0]   exc_cnt
`endif
);
    localparam int STAGES = 3;
    localparam int AW     = FW + 3;

    logic [STAGES:1] r_vld;
    logic            w_stall;
    logic            w_acc;

    assign w_stall   = r_vld[STAGES] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_acc     = in_valid & ~w_stall & ~flush;
    assign out_valid = r_vld[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_vld <= '0;
        else if (flush)    r_vld <= '0;
        else if (!w_stall) r_vld <= {r_vld[STAGES-1:1], w_acc};
    end

    // Zero-class flags carry no information beyond a zero significand here.
    logic w_unused_zero_flags;
    assign w_unused_zero_flags = &{1'b0, fla[3], flb[3]};

    // ---------------- S1: order operands and align the smaller one
    logic          w_swap, w_sbe;
    logic [FW:0]   w_fbig, w_fsml;
    logic [EW-1:0] w_ebig, w_d;
    logic [AW-1:0] w_sext, w_al, w_mask;
    logic          w_st;

    always_comb begin
        w_sbe  = sb ^ sub;
        w_swap = (eb > ea) | ((ea == eb) & (fb > fa));
        w_fbig = w_swap ? fb : fa;
        w_fsml = w_swap ? fa : fb;
        w_ebig = w_swap ? eb : ea;
        w_d    = w_swap ? (eb - ea) : (ea - eb);
        w_sext = {w_fsml, 2'b00};
        w_mask = ~({AW{1'b1}} << w_d);
        if (32'(w_d) >= AW) begin
            w_al = '0;
            w_st = |w_fsml;
        end else begin
            w_al = w_sext >> w_d;
            w_st = |(w_sext & w_mask);
        end
    end

    logic [EW-1:0] r_s1_es;
    logic [FW:0]   r_s1_fbig, r_s1_nan;
    logic [AW-1:0] r_s1_al;
    logic          r_s1_st, r_s1_sx, r_s1_sa, r_s1_sbe;
    logic [2:0]    r_s1_fla, r_s1_flb;
    logic [1:0]    r_s1_rm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_es   <= '0;
            r_s1_fbig <= '0;
            r_s1_nan  <= '0;
            r_s1_al   <= '0;
            r_s1_st   <= 1'b0;
            r_s1_sx   <= 1'b0;
            r_s1_sa   <= 1'b0;
            r_s1_sbe  <= 1'b0;
            r_s1_fla  <= '0;
            r_s1_flb  <= '0;
            r_s1_rm   <= '0;
        end else if (!w_stall) begin
            r_s1_es   <= w_ebig;
            r_s1_fbig <= w_fbig;
            r_s1_nan  <= nan;
            r_s1_al   <= w_al;
            r_s1_st   <= w_st;
            r_s1_sx   <= w_swap ? w_sbe : sa;
            r_s1_sa   <= sa;
            r_s1_sbe  <= w_sbe;
            r_s1_fla  <= fla[2:0];
            r_s1_flb  <= flb[2:0];
            r_s1_rm   <= RM;
        end
    end

    // ---------------- S2: magnitude add/subtract, sticky rides as the LSB
    logic [FW+4:0] w_big, w_sml, w_sum;
    logic          w_diff, w_neg, w_nans, w_inv, w_infs;

    always_comb begin
        w_big  = {1'b0, r_s1_fbig, 3'b000};
        w_sml  = {1'b0, r_s1_al, r_s1_st};
        w_diff = r_s1_sa ^ r_s1_sbe;
        w_neg  = w_diff & (w_sml > w_big);
        if (!w_diff)    w_sum = w_big + w_sml;
        else if (w_neg) w_sum = w_sml - w_big;
        else            w_sum = w_big - w_sml;
        w_nans = r_s1_fla[1] | r_s1_flb[1];
        w_inv  = (r_s1_fla[2] & r_s1_flb[2] & w_diff) | r_s1_fla[0] | r_s1_flb[0];
        w_infs = (r_s1_fla[2] | r_s1_flb[2]) & ~w_nans & ~w_inv;
    end

    logic [EW-1:0] r_s2_es;
    logic [FW+4:0] r_s2_fs;
    logic [FW:0]   r_s2_nan;
    logic          r_s2_sx, r_s2_diff, r_s2_sa, r_s2_infsg;
    logic          r_s2_nans, r_s2_inv, r_s2_infs;
    logic [1:0]    r_s2_rm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_es    <= '0;
            r_s2_fs    <= '0;
            r_s2_nan   <= '0;
            r_s2_sx    <= 1'b0;
            r_s2_diff  <= 1'b0;
            r_s2_sa    <= 1'b0;
            r_s2_infsg <= 1'b0;
            r_s2_nans  <= 1'b0;
            r_s2_inv   <= 1'b0;
            r_s2_infs  <= 1'b0;
            r_s2_rm    <= '0;
        end else if (!w_stall) begin
            r_s2_es    <= r_s1_es;
            r_s2_fs    <= w_sum;
            r_s2_nan   <= r_s1_nan;
            r_s2_sx    <= r_s1_sx ^ w_neg;
            r_s2_diff  <= w_diff;
            r_s2_sa    <= r_s1_sa;
            r_s2_infsg <= r_s1_fla[2] ? r_s1_sa : r_s1_sbe;
            r_s2_nans  <= w_nans;
            r_s2_inv   <= w_inv;
            r_s2_infs  <= w_infs;
            r_s2_rm    <= r_s1_rm;
        end
    end

    // ---------------- S3: result sign and class flags
    logic w_fszero, w_ss, w_zero;

    always_comb begin
        w_fszero = (r_s2_fs == '0);
        w_zero   = w_fszero & ~r_s2_nans & ~r_s2_infs & ~r_s2_inv;
        w_ss     = r_s2_sx;
        if (r_s2_nans | r_s2_inv) w_ss = 1'b0;
        else if (r_s2_infs)       w_ss = r_s2_infsg;
        else if (w_fszero)        w_ss = r_s2_diff ? (r_s2_rm == 2'b11) : r_s2_sa;
    end

    logic [EW-1:0] r_es;
    logic [FW+4:0] r_fs;
    logic          r_ss;
    logic [FW+5:0] r_fls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_es  <= '0;
            r_fs  <= '0;
            r_ss  <= 1'b0;
            r_fls <= '0;
        end else if (!w_stall) begin
            r_es  <= r_s2_es;
            r_fs  <= r_s2_fs;
            r_ss  <= w_ss;
            r_fls <= {r_s2_nan, w_zero, r_s2_infs, r_s2_nans, r_s2_inv, 1'b0};
        end
    end

    assign es  = r_es;
    assign fs  = r_fs;
    assign ss  = r_ss;
    assign fls = r_fls;

`ifdef FP_ADD_PIPE_EXC_CNT_EN
    logic [15:0] r_exc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_exc_cnt <= '0;
        else if (out_valid && out_ready && (r_fls[2] || r_fls[1]) && (r_exc_cnt != 16'hFFFF))
            r_exc_cnt <= r_exc_cnt + 16'd1;
    end

    assign exc_cnt = r_exc_cnt;
`endif

endmodule
